// File: rtl/result_display_scanner.sv
// result_display_scanner
//   Keeps the last NUM_DIGITS BNN results in a history shift register and drives a
//   time-multiplexed, common-anode 7-segment bank. It also owns the system heartbeat.
//   In status mode, digit 0 shows the controller status code in hex.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   result_ready     result_out is valid this cycle; sampled every cycle
//   result_out       BNN class; 0-9 are shown, 10-15 are shown as a blank digit
//   clear            flushes the history; wins over result_ready in the same cycle
//   display_mode     0 = result history, 1 = status code
//   status_code_reg  controller status code
//   seg              segments, active-low, bit6..0 = g..a (registered)
//   decimalPoint     high = DP lit (registered)
//   an               digit enables, active-low, one-hot-cold (registered)
//   heartbeat        liveness toggle (registered)
module result_display_scanner #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned HEARTBEAT_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  result_ready,
  input  logic [3:0]            result_out,
  input  logic                  clear,
  input  logic                  display_mode,
  input  logic [3:0]            status_code_reg,
  output logic [6:0]            seg,
  output logic                  decimalPoint,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  heartbeat
);

  // Each counter gets at least one bit, even when its parameter is 1.
  localparam int unsigned IDX_W = $clog2((NUM_DIGITS    < 2) ? 2 : NUM_DIGITS);
  localparam int unsigned REF_W = $clog2((REFRESH_DIV   < 2) ? 2 : REFRESH_DIV);
  localparam int unsigned HB_W  = $clog2((HEARTBEAT_DIV < 2) ? 2 : HEARTBEAT_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  // Active-low hex patterns, bit6..0 = g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // History entries: entry 0 is the newest and is shown on the rightmost digit.
  logic [NUM_DIGITS-1:0]      valid_q, valid_d;
  logic [NUM_DIGITS-1:0][3:0] value_q, value_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [REF_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  heartbeat_q, heartbeat_d;

  logic       sel_valid;
  logic [3:0] sel_value;

  // History shift register; clear takes priority and drops any coincident result.
  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    if (clear) begin
      valid_d = '0;
      value_d = '0;
    end else if (result_ready) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        value_d[i] = value_q[i-1];
      end
      valid_d[0] = 1'b1;
      value_d[0] = result_out;
    end
  end

  // Refresh divider and scan index; the index only moves on the divider wrap.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + REF_W'(1);
    idx_d         = idx_q;
    if (refresh_cnt_q == REF_LAST) begin
      refresh_cnt_d = '0;
      idx_d         = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Heartbeat divider.
  always_comb begin
    hb_cnt_d    = hb_cnt_q + HB_W'(1);
    heartbeat_d = heartbeat_q;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d    = '0;
      heartbeat_d = ~heartbeat_q;
    end
  end

  // Entry behind the currently selected digit.
  always_comb begin
    sel_valid = 1'b0;
    sel_value = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_valid = valid_q[i];
        sel_value = value_q[i];
      end
    end
  end

  // Digit decode from the current index/history/mode; registered below as one set.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = (idx_q != IDX_W'(i));
    end
    if (!display_mode) begin
      if (sel_valid && (sel_value <= 4'd9)) begin
        seg_d = hex_to_seg(sel_value);
      end
      dp_d = (idx_q == '0) && valid_q[0] && (value_q[0] <= 4'd9);
    end else if (idx_q == '0) begin
      seg_d = hex_to_seg(status_code_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      value_q       <= '0;
      idx_q         <= '0;
      refresh_cnt_q <= '0;
      hb_cnt_q      <= '0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b0;
      an_q          <= '1;
      heartbeat_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      value_q       <= value_d;
      idx_q         <= idx_d;
      refresh_cnt_q <= refresh_cnt_d;
      hb_cnt_q      <= hb_cnt_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      heartbeat_q   <= heartbeat_d;
    end
  end

  assign seg          = seg_q;
  assign decimalPoint = dp_q;
  assign an           = an_q;
  assign heartbeat    = heartbeat_q;

endmodule
